// File: rtl/k051962_pkg.sv
// Shared types and helpers for the K051962 layer pixel serializer.
package k051962_pkg;

   localparam int unsigned TILE_PIX = 8;
   localparam int unsigned BPP      = 4;
   localparam int unsigned ATTR_W   = 4;
   localparam int unsigned DATA_W   = TILE_PIX * BPP;
   localparam int unsigned SLOT_W   = DATA_W + ATTR_W + 1;
   localparam int unsigned OUT_W    = ATTR_W + BPP;
   localparam int unsigned PHASE_W  = 3;
   localparam int unsigned IDX_W    = PHASE_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ATTR_W-1:0] attr;
      logic              flip;
   } tile_slot_t;

   // Pixel at window position pos, mirrored when the tile is X-flipped.
   function automatic logic [BPP-1:0] pix_sel(tile_slot_t slot, logic [PHASE_W-1:0] pos);
      logic [PHASE_W-1:0] p;
      p = slot.flip ? (PHASE_W'(TILE_PIX - 1) - pos) : pos;
      return slot.data[32'(p) * BPP +: BPP];
   endfunction

endpackage

// File: rtl/k051962_layer_shifter_if.sv
// Tile-generator -> serializer -> mixer signal bundle for one tilemap layer.
interface k051962_layer_shifter_if;
   import k051962_pkg::*;

   logic                PIX_CE;
   logic                TILE_LD;
   logic [DATA_W-1:0]   ROM_D;
   logic [7:0]          COL;
   logic                FLIPX;
   logic [2:0]          FINE;
   logic                BLANK;
   logic [OUT_W-1:0]    DOUT;
   logic                TRANSP;
   logic                UNDERRUN;

   modport master (
      output PIX_CE, TILE_LD, ROM_D, COL, FLIPX, FINE, BLANK,
      input  DOUT, TRANSP, UNDERRUN
   );

   modport slave (
      input  PIX_CE, TILE_LD, ROM_D, COL, FLIPX, FINE, BLANK,
      output DOUT, TRANSP, UNDERRUN
   );

endinterface

// File: rtl/k051962_tile_slot.sv
// One tile slot: CE-qualified load/clear register with combinational pixel pick.
module k051962_tile_slot
   import k051962_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce,
   input  logic               i_ld,
   input  logic               i_clr,
   input  tile_slot_t         i_d,
   input  logic [PHASE_W-1:0] i_pos,
   output tile_slot_t         o_q,
   output logic [BPP-1:0]     o_pix_c
);

   tile_slot_t r_q;

   // Load wins over clear; both only on a pixel enable.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_ce) begin
         if (i_ld) begin
            r_q <= i_d;
         end else if (i_clr) begin
            r_q <= '0;
         end
      end
   end

   assign o_q     = r_q;
   assign o_pix_c = pix_sel(r_q, i_pos);

endmodule

// File: rtl/k051962_layer_shifter.sv
// Layer pixel serializer: two-tile window with fine scroll, registered {palette, pixel} out.
module k051962_layer_shifter
   import k051962_pkg::*;
(
   input  logic                     M24,
   input  logic                     RES,
   k051962_layer_shifter_if.slave   bus
);

   logic [PHASE_W-1:0] r_phase;
   logic [2:0]         r_fine_l;
   logic [OUT_W-1:0]   r_dout;
   logic               r_transp;
   logic               r_underrun;

   tile_slot_t         w_cur_q;
   tile_slot_t         w_next_q;
   tile_slot_t         w_next_d;
   logic [BPP-1:0]     w_cur_pix;
   logic [BPP-1:0]     w_next_pix;
   logic [IDX_W-1:0]   w_idx;
   logic               w_last;
   logic               w_underrun;
   logic               w_cur_ld;
   logic [BPP-1:0]     w_pix;
   logic [ATTR_W-1:0]  w_attr;

   assign w_last     = (r_phase == PHASE_W'(TILE_PIX - 1));
   assign w_underrun = !bus.TILE_LD && w_last;
   assign w_cur_ld   = bus.TILE_LD || w_last;
   assign w_idx      = {1'b0, r_phase} + {1'b0, r_fine_l};

   assign w_next_d.data = bus.ROM_D;
   assign w_next_d.attr = bus.COL[7 -: ATTR_W];
   assign w_next_d.flip = bus.FLIPX;

   k051962_tile_slot u_cur (
      .i_clk   (M24),
      .i_rst_n (RES),
      .i_ce    (bus.PIX_CE),
      .i_ld    (w_cur_ld),
      .i_clr   (1'b0),
      .i_d     (w_next_q),
      .i_pos   (w_idx[PHASE_W-1:0]),
      .o_q     (w_cur_q),
      .o_pix_c (w_cur_pix)
   );

   // NEXT empties to a transparent tile when a boundary passes without a load.
   k051962_tile_slot u_next (
      .i_clk   (M24),
      .i_rst_n (RES),
      .i_ce    (bus.PIX_CE),
      .i_ld    (bus.TILE_LD),
      .i_clr   (w_last),
      .i_d     (w_next_d),
      .i_pos   (w_idx[PHASE_W-1:0]),
      .o_q     (w_next_q),
      .o_pix_c (w_next_pix)
   );

   // Window index 0..7 reads CUR, 8..14 reads NEXT at idx-8.
   always_comb begin
      w_pix  = w_cur_pix;
      w_attr = w_cur_q.attr;
      if (w_idx[IDX_W-1]) begin
         w_pix  = w_next_pix;
         w_attr = w_next_q.attr;
      end
   end

   always_ff @(posedge M24 or negedge RES) begin
      if (!RES) begin
         r_phase    <= '0;
         r_fine_l   <= '0;
         r_dout     <= '0;
         r_transp   <= 1'b1;
         r_underrun <= 1'b0;
      end else if (bus.PIX_CE) begin
         if (bus.TILE_LD) begin
            r_phase  <= '0;
            r_fine_l <= bus.FINE;
         end else if (w_last) begin
            r_phase  <= '0;
         end else begin
            r_phase  <= r_phase + PHASE_W'(1);
         end
         r_underrun <= w_underrun;
         if (bus.BLANK) begin
            r_dout   <= '0;
            r_transp <= 1'b1;
         end else begin
            r_dout   <= {w_attr, w_pix};
            r_transp <= (w_pix == '0);
         end
      end
   end

   assign bus.DOUT     = r_dout;
   assign bus.TRANSP   = r_transp;
   assign bus.UNDERRUN = r_underrun;

endmodule

// File: tb/tb_k051962_layer_shifter.sv
// Directed bench for the K051962 layer serializer: window order, flip, fine scroll, underrun, blank, reset.
module tb_k051962_layer_shifter;
   import k051962_pkg::*;

   logic M24;
   logic RES;
   int   n_vec;
   int   n_err;

   k051962_layer_shifter_if bus ();

   k051962_layer_shifter dut (
      .M24 (M24),
      .RES (RES),
      .bus (bus)
   );

   initial M24 = 1'b0;
   always #5 M24 = ~M24;

   logic [31:0] rom_t [5] = '{32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h22222221, 32'h00000000};
   logic [7:0]  col_t [5] = '{8'hA0, 8'h50, 8'h30, 8'h90, 8'h00};

   logic [7:0] exp2 [16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                             8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F};
   logic [7:0] exp3 [8]  = '{8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
   logic [7:0] exp4 [25] = '{8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h58, 8'h59, 8'h5A,
                             8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h3F, 8'h3D, 8'h3B,
                             8'h39, 8'h37, 8'h35, 8'h33, 8'h31, 8'h91, 8'h92, 8'h92, 8'h91};
   logic [7:0] exp6 [9]  = '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA6, 8'hA7, 8'h58};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Three idle M24 cycles, then one PIX_CE cycle; returns 1 time unit after its edge.
   task automatic step(input bit ld, input int t, input bit fl, input logic [2:0] fn, input bit bl);
      repeat (3) @(posedge M24);
      #1;
      bus.TILE_LD = ld;
      bus.ROM_D   = ld ? rom_t[t] : 32'hDEADBEEF;
      bus.COL     = ld ? col_t[t] : 8'hFF;
      bus.FLIPX   = fl;
      bus.FINE    = fn;
      bus.BLANK   = bl;
      bus.PIX_CE  = 1'b1;
      @(posedge M24);
      #1;
      bus.PIX_CE  = 1'b0;
      bus.TILE_LD = 1'b0;
      bus.BLANK   = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      RES = 1'b0;
      repeat (2) @(posedge M24);
      #1;
      RES = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      RES = 1'b0;
      bus.PIX_CE = 1'b0; bus.TILE_LD = 1'b0; bus.ROM_D = '0; bus.COL = '0;
      bus.FLIPX = 1'b0; bus.FINE = '0; bus.BLANK = 1'b0;
      repeat (2) @(posedge M24);
      #1;
      chk("rst_dout", bus.DOUT, 8'h00);
      chk("rst_transp", 8'(bus.TRANSP), 8'h01);
      chk("rst_underrun", 8'(bus.UNDERRUN), 8'h00);
      RES = 1'b1;

      // Plain sequence, FINE=0, loads every 8 pixels.
      for (int i = 0; i <= 24; i++) begin
         step(i % 8 == 0, i / 8, 1'b0, 3'd0, 1'b0);
         if (i >= 9) chk($sformatf("seq_%0d", i), bus.DOUT, exp2[i-9]);
         if (i == 9) chk("seq_transp_px0", 8'(bus.TRANSP), 8'h01);
         if (i == 10) chk("seq_transp_px1", 8'(bus.TRANSP), 8'h00);
         if (i == 12) chk("seq_underrun", 8'(bus.UNDERRUN), 8'h00);
      end

      // Asynchronous reset mid-stream clears outputs immediately.
      #2;
      RES = 1'b0;
      #1;
      chk("mid_rst_dout", bus.DOUT, 8'h00);
      chk("mid_rst_transp", 8'(bus.TRANSP), 8'h01);
      chk("mid_rst_underrun", 8'(bus.UNDERRUN), 8'h00);
      repeat (2) @(posedge M24);
      #1;
      RES = 1'b1;
      step(1'b1, 0, 1'b0, 3'd0, 1'b0);
      chk("post_rst_dout", bus.DOUT, 8'h00);
      chk("post_rst_transp", 8'(bus.TRANSP), 8'h01);

      // X-flip on the first tile.
      do_reset();
      for (int i = 0; i <= 16; i++) begin
         step(i % 8 == 0, i / 8, i == 0, 3'd0, 1'b0);
         if (i >= 9) chk($sformatf("flip_%0d", i), bus.DOUT, exp3[i-9]);
      end

      // Fine scroll 3, FINE wiggled mid-tile, then FINE=0 latched at the last load.
      do_reset();
      for (int i = 0; i <= 33; i++) begin
         logic [2:0] fn;
         fn = (i >= 17 && i <= 23) ? 3'd5 : ((i == 32) ? 3'd0 : 3'd3);
         step(i % 8 == 0, i / 8, 1'b0, fn, 1'b0);
         if (i >= 9) chk($sformatf("fine_%0d", i), bus.DOUT, exp4[i-9]);
      end

      // Underrun: loads stop after the second tile.
      do_reset();
      for (int i = 0; i <= 25; i++) begin
         step(i == 0 || i == 8, i / 8, 1'b0, 3'd0, 1'b0);
         if (i == 15) chk("ur_before", 8'(bus.UNDERRUN), 8'h00);
         if (i == 16) begin
            chk("ur_pulse", 8'(bus.UNDERRUN), 8'h01);
            chk("ur_dout16", bus.DOUT, 8'hA7);
         end
         if (i == 17) begin
            chk("ur_clear", 8'(bus.UNDERRUN), 8'h00);
            chk("ur_dout17", bus.DOUT, 8'h58);
            repeat (2) @(posedge M24);
            #1;
            chk("ur_gap_hold", bus.DOUT, 8'h58);
            chk("ur_gap_underrun", 8'(bus.UNDERRUN), 8'h00);
         end
         if (i == 24) chk("ur_dout24", bus.DOUT, 8'h5F);
         if (i == 25) begin
            chk("ur_empty_dout", bus.DOUT, 8'h00);
            chk("ur_empty_transp", 8'(bus.TRANSP), 8'h01);
         end
      end

      // BLANK for four pixels inside the first tile.
      do_reset();
      for (int i = 0; i <= 17; i++) begin
         step(i % 8 == 0, i / 8, 1'b0, 3'd0, i >= 11 && i <= 14);
         if (i >= 9) chk($sformatf("blank_%0d", i), bus.DOUT, exp6[i-9]);
         if (i == 11) chk("blank_transp", 8'(bus.TRANSP), 8'h01);
         if (i == 15) chk("unblank_transp", 8'(bus.TRANSP), 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
